// File: rtl/apb_manager.sv
// APB requester for one CPU port: queues valid/ready commands, issues them as
// APB SETUP/ACCESS transfers and returns rdata/slverr in command order.
package apb_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              slverr;
    } apb_resp_t;
endpackage

module apb_manager
    import apb_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_cmd_valid,
    output logic      o_cmd_ready,
    input  apb_req_t  i_cmd_req,
    output logic      o_rsp_valid,
    input  logic      i_rsp_ready,
    output apb_resp_t o_rsp,
    output apb_req_t  o_apb_m_req,
    input  apb_resp_t i_apb_m_resp,
    output logic      o_apb_m_psel,
    output logic      o_apb_m_penable,
    input  logic      i_apb_m_pready,
    output logic      o_busy
);
    localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e           state_q, state_d;
    apb_req_t         fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    apb_req_t         req_q, req_d;
    apb_resp_t        rsp_q, rsp_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;

    logic push, pop, fifo_empty, start, done_ok, done_tmo, tmo_hit;

    assign fifo_empty  = (count_q == '0);
    assign o_cmd_ready = (count_q != CNT_W'(CMD_DEPTH));
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = done_ok || done_tmo;

    // Abort fires on the ACCESS cycle whose increment would bring the count to the limit.
    always_comb begin
        tmo_hit = 1'b0;
        if (TIMEOUT_CYCLES > 0) begin
            tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        done_ok  = 1'b0;
        done_tmo = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && (!rsp_valid_q || i_rsp_ready)) begin
                    state_d = SETUP;
                    start   = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (i_apb_m_pready) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    done_tmo = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        req_d       = start ? fifo_mem[rd_ptr_q] : req_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        if (rsp_valid_q && i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (done_ok) begin
            rsp_valid_d  = 1'b1;
            rsp_d.slverr = i_apb_m_resp.slverr;
            rsp_d.rdata  = req_q.write ? '0 : i_apb_m_resp.rdata;
        end else if (done_tmo) begin
            rsp_valid_d  = 1'b1;
            rsp_d.slverr = 1'b1;
            rsp_d.rdata  = '0;
        end
        tmo_d = tmo_q;
        if (state_q == SETUP) begin
            tmo_d = '0;
        end else if ((TIMEOUT_CYCLES > 0) && (state_q == ACCESS) && !i_apb_m_pready) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            req_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_cmd_req;
        end
    end

    assign o_apb_m_req     = req_q;
    assign o_apb_m_psel    = psel_q;
    assign o_apb_m_penable = penable_q;
    assign o_rsp           = rsp_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_busy          = (state_q != IDLE) || !fifo_empty || rsp_valid_q;

endmodule
